adder_avst_param: RTL

ADDER_AVST_PARAM -- requirements
Module: adder_avst_param

---
 rtl/adder_avst_pkg.sv | 18 +
 rtl/avst_beat_serializer.sv | 78 +++++++
 rtl/adder_avst_param.sv | 93 +++++++++
 3 files changed

// File: rtl/adder_avst_pkg.sv
// Shared types and derived-constant helpers for the streaming accumulator.
package adder_avst_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    function automatic int calc_nbeats(input int sum_w, input int data_w);
        return sum_w / data_w;
    endfunction

    // Beat counter width; a single-beat result still needs a 1-bit counter.
    function automatic int calc_beat_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/avst_beat_serializer.sv
// Loads a SUM_W result word plus overflow flag and streams it out MSB slice first
// as registered DATA_W beats with sop/end framing and valid/ready flow control.
module avst_beat_serializer
    import adder_avst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SUM_W-1:0]  word_in,
    input  logic              ovf_in,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              end_out,
    output logic              ovf_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              last_done
);

    localparam int NBEATS = calc_nbeats(SUM_W, DATA_W);
    localparam int BEAT_W = calc_beat_w(NBEATS);

    logic [SUM_W-1:0]  shreg;
    logic [SUM_W-1:0]  shifted;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_next;
    logic              ovf_hold;
    logic              advance;

    assign advance   = valid_out && ready_out;
    assign last_done = advance && end_out;
    assign shifted   = shreg << DATA_W;
    assign beat_next = beat + BEAT_W'(1);

    // NOTE: every register here is sequential state, so all updates use <= to
    // sample pre-edge values; blocking assignments would race between flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            beat      <= '0;
            ovf_hold  <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            end_out   <= 1'b0;
            ovf_out   <= 1'b0;
            valid_out <= 1'b0;
        end else if (load) begin
            shreg     <= word_in;
            beat      <= '0;
            ovf_hold  <= ovf_in;
            data_out  <= word_in[SUM_W-1 -: DATA_W];
            sop_out   <= 1'b1;
            end_out   <= (NBEATS == 1);
            ovf_out   <= (NBEATS == 1) ? ovf_in : 1'b0;
            valid_out <= 1'b1;
        end else if (advance) begin
            if (end_out) begin
                data_out  <= '0;
                sop_out   <= 1'b0;
                end_out   <= 1'b0;
                ovf_out   <= 1'b0;
                valid_out <= 1'b0;
                beat      <= '0;
            end else begin
                shreg    <= shifted;
                beat     <= beat_next;
                data_out <= shifted[SUM_W-1 -: DATA_W];
                sop_out  <= 1'b0;
                end_out  <= (beat_next == BEAT_W'(NBEATS - 1));
                ovf_out  <= (beat_next == BEAT_W'(NBEATS - 1)) && ovf_hold;
            end
        end
    end

endmodule

// File: rtl/adder_avst_param.sv
// Packet accumulator: sums input beats (signed or unsigned, modulo 2^SUM_W) until
// end_in, then hands the total and a sticky overflow flag to the beat serializer.
module adder_avst_param
    import adder_avst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              sop_out,
    output logic              end_out,
    output logic              ovf_out,
    output logic              valid_out,
    input  logic              ready_out
);

    state_t           state;
    logic [SUM_W-1:0] sum;
    logic             ovf;
    logic [SUM_W-1:0] ext;
    logic [SUM_W-1:0] sum_next;
    logic             carry;
    logic             ovf_step;
    logic             ovf_next;
    logic             accept;
    logic             last_done;

    assign ext = (SIGNED != 0) ? SUM_W'($signed(data_in)) : SUM_W'(data_in);
    assign {carry, sum_next} = {1'b0, sum} + {1'b0, ext};

    // Signed overflow: operands share a sign that the result does not.
    assign ovf_step = (SIGNED != 0)
                    ? ((sum[SUM_W-1] == ext[SUM_W-1]) && (sum_next[SUM_W-1] != sum[SUM_W-1]))
                    : carry;
    assign ovf_next = ovf | ovf_step;
    assign accept   = valid_in && ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            sum      <= '0;
            ovf      <= 1'b0;
            ready_in <= 1'b1;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    sum <= sum_next;
                    ovf <= ovf_next;
                    if (end_in) begin
                        state    <= EMIT;
                        ready_in <= 1'b0;
                    end
                end
                EMIT: if (last_done) begin
                    state    <= ACCUM;
                    sum      <= '0;
                    ovf      <= 1'b0;
                    ready_in <= 1'b1;
                end
                default: begin
                    state    <= ACCUM;
                    ready_in <= 1'b1;
                end
            endcase
        end
    end

    avst_beat_serializer #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && end_in),
        .word_in   (sum_next),
        .ovf_in    (ovf_next),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .end_out   (end_out),
        .ovf_out   (ovf_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_done (last_done)
    );

endmodule
